// File: rtl/ms_conv_seq_if.sv
// Signal bundle between the multi-slope sequencer, the integrator switch drivers/comparator
// and the result consumer. The sequencer takes the slave side.
interface ms_conv_seq_if #(
    parameter int NSTAGE = 3,
    parameter int RD_W   = 12,
    parameter int STG_W  = 8,
    parameter int NPL_W  = 10
);
    logic                    start;
    logic                    meas_zero;
    logic [NPL_W-1:0]        npl;
    logic                    cmp;
    logic                    sinput;
    logic                    szero;
    logic                    sp_main;
    logic                    sn_main;
    logic [NSTAGE-1:0]       s_stage;
    logic                    busy;
    logic                    res_valid;
    logic                    res_ready;
    logic [NPL_W-1:0]        res_cnt_n;
    logic [NPL_W-1:0]        res_cnt_p;
    logic [RD_W-1:0]         res_rd;
    logic [NSTAGE*STG_W-1:0] res_stg;
    logic                    res_err;
    logic                    overrun;

    modport master (
        output start, meas_zero, npl, cmp, res_ready,
        input  sinput, szero, sp_main, sn_main, s_stage, busy,
               res_valid, res_cnt_n, res_cnt_p, res_rd, res_stg, res_err, overrun
    );

    modport slave (
        input  start, meas_zero, npl, cmp, res_ready,
        output sinput, szero, sp_main, sn_main, s_stage, busy,
               res_valid, res_cnt_n, res_cnt_p, res_rd, res_stg, res_err, overrun
    );
endinterface

// File: rtl/ms_conv_seq.sv
// Multi-slope ADC conversion sequencer: PWM run-up, main run-down, NSTAGE residue slopes,
// dead time between phases, timeout by counter saturation and a valid/ready result port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | all switches off, waiting for start
// S_RUNUP   | input/zero integration with comparator-steered PWM
// S_DEAD    | all switches off for DEAD_CYC clocks, then enter ret_q
// S_RUNDOWN | sp_main on until cmp=0
// S_STAGE   | s_stage[stg_idx_q] on until cmp reaches the stage's end level
// S_DONE    | publish counters to the result port
module ms_conv_seq #(
    parameter int PWM_PERIOD = 250,
    parameter int PWM_LONG   = 200,
    parameter int NSTAGE     = 3,
    parameter int RD_W       = 12,
    parameter int STG_W      = 8,
    parameter int NPL_W      = 10,
    parameter int DEAD_CYC   = 1
) (
    input logic          clk,
    input logic          rst,
    ms_conv_seq_if.slave bus
);
    localparam int PP_W = $clog2(PWM_PERIOD);
    localparam int SI_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam int DC_W = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_RUNUP, S_DEAD, S_RUNDOWN, S_STAGE, S_DONE
    } state_t;

    state_t                  state_q, state_d, ret_q, ret_d, next_ph;
    logic [SI_W-1:0]         stg_idx_q, stg_idx_d, next_idx;
    logic [DC_W-1:0]         dead_q, dead_d;
    logic [PP_W-1:0]         pos_q, pos_d;
    logic                    dom_n_q, dom_n_d;
    logic [NPL_W-1:0]        per_left_q, per_left_d;
    logic                    mz_q, mz_d;
    logic [NPL_W-1:0]        cnt_n_q, cnt_n_d, cnt_p_q, cnt_p_d;
    logic [RD_W-1:0]         rd_q, rd_d;
    logic [NSTAGE*STG_W-1:0] stg_q, stg_d;
    logic                    err_q, err_d;
    logic [STG_W-1:0]        stg_inc;
    logic                    advance, pwm_n;

    logic                    sinput_q, sinput_d, szero_q, szero_d;
    logic                    sp_q, sp_d, sn_q, sn_d;
    logic [NSTAGE-1:0]       s_stage_q, s_stage_d;
    logic                    busy_q, busy_d;
    logic                    res_valid_q, res_valid_d;
    logic [NPL_W-1:0]        res_cnt_n_q, res_cnt_n_d, res_cnt_p_q, res_cnt_p_d;
    logic [RD_W-1:0]         res_rd_q, res_rd_d;
    logic [NSTAGE*STG_W-1:0] res_stg_q, res_stg_d;
    logic                    res_err_q, res_err_d;
    logic                    overrun_q, overrun_d;

    assign stg_inc = stg_q[int'(stg_idx_q)*STG_W +: STG_W] + STG_W'(1);

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        stg_idx_d   = stg_idx_q;
        dead_d      = dead_q;
        pos_d       = pos_q;
        dom_n_d     = dom_n_q;
        per_left_d  = per_left_q;
        mz_d        = mz_q;
        cnt_n_d     = cnt_n_q;
        cnt_p_d     = cnt_p_q;
        rd_d        = rd_q;
        stg_d       = stg_q;
        err_d       = err_q;
        res_cnt_n_d = res_cnt_n_q;
        res_cnt_p_d = res_cnt_p_q;
        res_rd_d    = res_rd_q;
        res_stg_d   = res_stg_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q & ~bus.res_ready;
        overrun_d   = overrun_q;
        advance     = 1'b0;
        next_ph     = S_RUNDOWN;
        next_idx    = stg_idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_RUNUP;
                    mz_d       = bus.meas_zero;
                    per_left_d = (bus.npl == '0) ? '0 : bus.npl - NPL_W'(1);
                    pos_d      = '0;
                    dom_n_d    = bus.cmp;
                    cnt_n_d    = NPL_W'(bus.cmp);
                    cnt_p_d    = NPL_W'(!bus.cmp);
                    rd_d       = '0;
                    stg_d      = '0;
                    err_d      = 1'b0;
                    stg_idx_d  = '0;
                end
            end
            S_RUNUP: begin
                if (int'(pos_q) == PWM_PERIOD - 1) begin
                    if (per_left_q == '0) begin
                        advance = 1'b1;
                        next_ph = S_RUNDOWN;
                    end else begin
                        // period boundary: cmp picks the dominant polarity of the coming period
                        per_left_d = per_left_q - NPL_W'(1);
                        pos_d      = '0;
                        dom_n_d    = bus.cmp;
                        if (bus.cmp) cnt_n_d = cnt_n_q + NPL_W'(1);
                        else         cnt_p_d = cnt_p_q + NPL_W'(1);
                    end
                end else begin
                    pos_d = pos_q + PP_W'(1);
                end
            end
            S_DEAD: begin
                if (dead_q == '0) state_d = ret_q;
                else              dead_d  = dead_q - DC_W'(1);
            end
            S_RUNDOWN: begin
                rd_d = rd_q + RD_W'(1);
                if (&rd_d) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!bus.cmp) begin
                    advance  = 1'b1;
                    next_ph  = S_STAGE;
                    next_idx = '0;
                end
            end
            S_STAGE: begin
                stg_d[int'(stg_idx_q)*STG_W +: STG_W] = stg_inc;
                if (&stg_inc) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (bus.cmp == ~stg_idx_q[0]) begin
                    // even stages end on cmp=1, odd stages on cmp=0
                    if (int'(stg_idx_q) == NSTAGE - 1) begin
                        state_d = S_DONE;
                    end else begin
                        advance  = 1'b1;
                        next_ph  = S_STAGE;
                        next_idx = stg_idx_q + SI_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                res_cnt_n_d = cnt_n_q;
                res_cnt_p_d = cnt_p_q;
                res_rd_d    = rd_q;
                res_stg_d   = stg_q;
                res_err_d   = err_q;
                res_valid_d = 1'b1;
                if (res_valid_q && !bus.res_ready) overrun_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            stg_idx_d = next_idx;
            if (DEAD_CYC == 0) begin
                state_d = next_ph;
            end else begin
                state_d = S_DEAD;
                ret_d   = next_ph;
                dead_d  = DC_W'(DEAD_CYC - 1);
            end
        end

        // switch drives are registered decodes of the next state
        pwm_n     = dom_n_d ? (int'(pos_d) < PWM_LONG) : (int'(pos_d) >= PWM_LONG);
        busy_d    = (state_d != S_IDLE);
        sinput_d  = (state_d == S_RUNUP) && !mz_d;
        szero_d   = (state_d == S_RUNUP) && mz_d;
        sn_d      = (state_d == S_RUNUP) && pwm_n;
        sp_d      = ((state_d == S_RUNUP) && !pwm_n) || (state_d == S_RUNDOWN);
        s_stage_d = (state_d == S_STAGE) ? (NSTAGE'(1) << stg_idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            stg_idx_q   <= '0;
            dead_q      <= '0;
            pos_q       <= '0;
            dom_n_q     <= 1'b0;
            per_left_q  <= '0;
            mz_q        <= 1'b0;
            cnt_n_q     <= '0;
            cnt_p_q     <= '0;
            rd_q        <= '0;
            stg_q       <= '0;
            err_q       <= 1'b0;
            sinput_q    <= 1'b0;
            szero_q     <= 1'b0;
            sp_q        <= 1'b0;
            sn_q        <= 1'b0;
            s_stage_q   <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_cnt_n_q <= '0;
            res_cnt_p_q <= '0;
            res_rd_q    <= '0;
            res_stg_q   <= '0;
            res_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            stg_idx_q   <= stg_idx_d;
            dead_q      <= dead_d;
            pos_q       <= pos_d;
            dom_n_q     <= dom_n_d;
            per_left_q  <= per_left_d;
            mz_q        <= mz_d;
            cnt_n_q     <= cnt_n_d;
            cnt_p_q     <= cnt_p_d;
            rd_q        <= rd_d;
            stg_q       <= stg_d;
            err_q       <= err_d;
            sinput_q    <= sinput_d;
            szero_q     <= szero_d;
            sp_q        <= sp_d;
            sn_q        <= sn_d;
            s_stage_q   <= s_stage_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_cnt_n_q <= res_cnt_n_d;
            res_cnt_p_q <= res_cnt_p_d;
            res_rd_q    <= res_rd_d;
            res_stg_q   <= res_stg_d;
            res_err_q   <= res_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.sinput    = sinput_q;
    assign bus.szero     = szero_q;
    assign bus.sp_main   = sp_q;
    assign bus.sn_main   = sn_q;
    assign bus.s_stage   = s_stage_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_cnt_n = res_cnt_n_q;
    assign bus.res_cnt_p = res_cnt_p_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_stg   = res_stg_q;
    assign bus.res_err   = res_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_ms_conv_seq.sv
// Bench for ms_conv_seq: a negedge responder plays the integrator comparator from per-phase
// target lengths, and each conversion is checked against arithmetic expectations.
module tb_ms_conv_seq;
    localparam int PWM_PERIOD = 250;
    localparam int PWM_LONG   = 200;
    localparam int NSTAGE     = 3;
    localparam int RD_W       = 12;
    localparam int STG_W      = 8;
    localparam int NPL_W      = 10;
    localparam int DEAD_CYC   = 1;
    localparam int RD_MAX     = (1 << RD_W) - 1;
    localparam int STG_MAX    = (1 << STG_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ms_conv_seq_if #(.NSTAGE(NSTAGE), .RD_W(RD_W), .STG_W(STG_W), .NPL_W(NPL_W)) bus ();

    ms_conv_seq #(
        .PWM_PERIOD(PWM_PERIOD), .PWM_LONG(PWM_LONG), .NSTAGE(NSTAGE), .RD_W(RD_W),
        .STG_W(STG_W), .NPL_W(NPL_W), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // comparator scenario shared with the responder
    logic [7:0] pat_q = '0;
    int         exp_l = 1;
    int         exp_s [NSTAGE];

    // statistics of the current conversion
    int  ru_cyc, sn_ru, sin_cyc, sz_cyc, rd_cyc, off_cyc, busy_cyc, viol;
    int  st_cyc [NSTAGE];
    bit  prev_busy = 1'b0;

    // result-port model
    bit m_valid = 1'b0;
    bit m_over  = 1'b0;

    always @(negedge clk) begin
        int nsw;
        if (bus.busy && !prev_busy) begin
            ru_cyc = 0; sn_ru = 0; sin_cyc = 0; sz_cyc = 0; rd_cyc = 0;
            off_cyc = 0; busy_cyc = 0; viol = 0;
            for (int k = 0; k < NSTAGE; k++) st_cyc[k] = 0;
        end
        prev_busy = bus.busy;
        if (bus.busy) begin
            busy_cyc++;
            nsw = int'(bus.sp_main) + int'(bus.sn_main) + $countones(bus.s_stage);
            if (bus.sinput && bus.szero) viol++;
            if (bus.sinput || bus.szero) begin
                if (int'(bus.sp_main) + int'(bus.sn_main) != 1 || bus.s_stage != '0) viol++;
            end else if (nsw > 1) viol++;
            if (!(bus.sinput || bus.szero) && nsw == 0) off_cyc++;
            if (bus.sinput) sin_cyc++;
            if (bus.szero) sz_cyc++;
            if (bus.sinput || bus.szero) begin
                ru_cyc++;
                if (bus.sn_main) sn_ru++;
                if (ru_cyc % PWM_PERIOD == 0) bus.cmp = pat_q[(ru_cyc / PWM_PERIOD) & 7];
            end else if (bus.sp_main) begin
                rd_cyc++;
                bus.cmp = (rd_cyc == exp_l) ? 1'b0 : 1'b1;
            end else begin
                for (int k = 0; k < NSTAGE; k++) begin
                    if (bus.s_stage[k]) begin
                        st_cyc[k]++;
                        bus.cmp = (st_cyc[k] == exp_s[k]) ? (k % 2 == 0) : (k % 2 != 0);
                    end
                end
            end
        end else begin
            bus.cmp = pat_q[0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input int npl_v, input bit mz, input logic [7:0] pat_v,
                              input int l, input int s0, input int s1, input int s2);
        pat_q = pat_v;
        exp_l = l;
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2;
        @(negedge clk);
        @(negedge clk);
        bus.meas_zero = mz;
        bus.npl       = NPL_W'(npl_v);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_sinput", 32'(bus.sinput), 32'(!mz));
        chk("start_szero", 32'(bus.szero), 32'(mz));
        chk("start_sn", 32'(bus.sn_main), 32'(pat_v[0]));
    endtask

    task automatic run_conv(input string tag, input int npl_v, input bit mz,
                            input logic [7:0] pat_v, input int l,
                            input int s0, input int s1, input int s2, input bit accept);
        int nper, e_n, e_rd, e_off, e_sum, sl;
        bit e_err, done;
        logic [NSTAGE*STG_W-1:0] e_stg;

        nper = (npl_v == 0) ? 1 : npl_v;
        e_n = 0;
        for (int i = 0; i < nper; i++) e_n += int'(pat_v[i]);
        e_err = 1'b0;
        e_stg = '0;
        e_off = DEAD_CYC + 1;
        if (l >= RD_MAX) begin
            e_rd = RD_MAX; e_err = 1'b1; e_sum = RD_MAX;
        end else begin
            e_rd = l; e_sum = l; e_off += DEAD_CYC;
            for (int k = 0; k < NSTAGE; k++) begin
                sl = (k == 0) ? s0 : (k == 1) ? s1 : s2;
                if (sl >= STG_MAX) begin
                    e_stg[k*STG_W +: STG_W] = STG_W'(STG_MAX);
                    e_sum += STG_MAX; e_err = 1'b1;
                    break;
                end
                e_stg[k*STG_W +: STG_W] = STG_W'(sl);
                e_sum += sl;
                if (k < NSTAGE - 1) e_off += DEAD_CYC;
            end
        end

        start_conv(npl_v, mz, pat_v, l, s0, s1, s2);
        repeat (10) @(negedge clk);
        bus.meas_zero = !mz;
        bus.npl       = NPL_W'(7);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, ".done"}, 32'(done), 1);
        if (m_valid) m_over = 1'b1;
        m_valid = 1'b1;

        chk({tag, ".cnt_n"}, 32'(bus.res_cnt_n), 32'(e_n));
        chk({tag, ".cnt_p"}, 32'(bus.res_cnt_p), 32'(nper - e_n));
        chk({tag, ".rd"}, 32'(bus.res_rd), 32'(e_rd));
        chk({tag, ".stg"}, 32'(bus.res_stg), 32'(e_stg));
        chk({tag, ".err"}, 32'(bus.res_err), 32'(e_err));
        chk({tag, ".valid"}, 32'(bus.res_valid), 32'(m_valid));
        chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_over));
        chk({tag, ".runup_len"}, 32'(ru_cyc), 32'(nper * PWM_PERIOD));
        chk({tag, ".sn_runup"}, 32'(sn_ru),
            32'(e_n * PWM_LONG + (nper - e_n) * (PWM_PERIOD - PWM_LONG)));
        chk({tag, ".sinput_len"}, 32'(sin_cyc), mz ? 0 : 32'(nper * PWM_PERIOD));
        chk({tag, ".szero_len"}, 32'(sz_cyc), mz ? 32'(nper * PWM_PERIOD) : 0);
        chk({tag, ".all_off"}, 32'(off_cyc), 32'(e_off));
        chk({tag, ".busy_len"}, 32'(busy_cyc), 32'(nper * PWM_PERIOD + e_sum + e_off));
        chk({tag, ".overlap"}, 32'(viol), 0);

        if (accept) begin
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
            m_valid = 1'b0;
            chk({tag, ".valid_drop"}, 32'(bus.res_valid), 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.meas_zero = 1'b0;
        bus.npl = '0;
        bus.res_ready = 1'b0;
        for (int k = 0; k < NSTAGE; k++) exp_s[k] = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst.switches", 32'({bus.sinput, bus.szero, bus.sp_main, bus.sn_main, bus.s_stage}), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.valid", 32'(bus.res_valid), 0);
        chk("rst.overrun", 32'(bus.overrun), 0);
        chk("rst.rd", 32'(bus.res_rd), 0);

        run_conv("basic", 2, 1'b0, 8'hFF, 37, 5, 9, 3, 1'b1);
        run_conv("timeout", 1, 1'b0, 8'h00, 100000, 5, 5, 5, 1'b1);
        run_conv("ovr_a", 3, 1'b0, 8'b0000_0101, 20, 4, 6, 8, 1'b0);
        run_conv("ovr_b", 2, 1'b0, 8'b0000_0010, 50, 7, 2, 11, 1'b1);
        run_conv("zero", 0, 1'b1, 8'h5A, 12, 3, 3, 3, 1'b0);

        // abort in STAGE(1) with an unaccepted result and a set overrun flag
        start_conv(1, 1'b0, 8'h01, 30, 6, 40, 6);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.s_stage[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("abort.reach_stage1", 32'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        chk("abort.switches", 32'({bus.sinput, bus.szero, bus.sp_main, bus.sn_main, bus.s_stage}), 0);
        chk("abort.busy", 32'(bus.busy), 0);
        chk("abort.valid", 32'(bus.res_valid), 0);
        chk("abort.overrun", 32'(bus.overrun), 0);
        chk("abort.stg", 32'(bus.res_stg), 0);

        for (int r = 0; r < 5; r++) begin
            run_conv("rand", int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                     8'($urandom), int'($urandom_range(1, 400)),
                     int'($urandom_range(1, 200)), int'($urandom_range(1, 200)),
                     int'($urandom_range(1, 200)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ms_conv_seq.md
# ms_conv_seq

Parametrised, fully synchronous multi-slope ADC conversion sequencer: zero/input run-up with comparator-steered PWM, main run-down, then NSTAGE alternating-polarity residue slopes, each timed by a saturating counter. It supersedes the fixed three-residue controller by adding a configurable stage count, counter widths, PWM shape, run-up length, an auto-zero mode, dead time between phases, timeout and a valid/ready result port. It sits between the integrator switch drivers/comparator and the result-processing logic.

## Interface
- PWM_PERIOD, 250: clocks per run-up PWM period (≥4).
- PWM_LONG, 200: clocks of dominant polarity per period (1..PWM_PERIOD-1).
- NSTAGE, 3: residue stages after main run-down (1..4).
- RD_W, 12: main run-down counter width.
- STG_W, 8: residue-stage counter width.
- NPL_W, 10: run-up period count width.
- DEAD_CYC, 1: all-switches-off clocks between phases (0..7).
- clk  in  1  system clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- start  in  1  start pulse, honoured only in IDLE.
- meas_zero  in  1  sampled with start: 1 = integrate zero (szero) during run-up instead of input.
- npl  in  NPL_W  run-up length in PWM periods, sampled with start; 0 treated as 1.
- cmp  in  1  integrator comparator, 1 = integrator above zero; already synchronised.
- sinput, szero  out  1  input / zero switch.
- sp_main, sn_main  out  1  main positive / negative reference switch.
- s_stage  out  NSTAGE  residue switch per stage.
- busy  out  1  high outside IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_cnt_n, res_cnt_p  out  NPL_W  run-up periods that were N-/P-dominant.
- res_rd  out  RD_W  main run-down clocks.
- res_stg  out  NSTAGE*STG_W  stage k in bits [k*STG_W +: STG_W].
- res_err  out  1  timeout in this result.
- overrun  out  1  sticky: result overwritten while unaccepted.

## Operation
- States: IDLE, RUNUP, DEAD, RUNDOWN, STAGE(k), DONE.
- IDLE: all switches 0. start=1 latches meas_zero, npl; clears working counters; → RUNUP.
- RUNUP: sinput=1 (or szero=1 if meas_zero). Period clock 0 samples cmp: cmp=1 → N-dominant: sn_main for PWM_LONG clocks, then sp_main for rest; cnt_n++. cmp=0 → mirror; cnt_p++. Exactly one of sp_main/sn_main high every run-up clock. After npl periods → DEAD → RUNDOWN.
- RUNDOWN: sp_main=1; ends on first clock with cmp=0. → DEAD → STAGE(0).
- STAGE(k): s_stage[k]=1; even k ends when cmp=1, odd k ends when cmp=0. k<NSTAGE-1 → DEAD → STAGE(k+1); last → DONE.
- DEAD: all switches 0 for DEAD_CYC clocks; skipped when 0.
- Counters count clocks spent in the phase, including the terminating clock; saturate at all-ones. Saturation = timeout: res_err=1, skip remaining stages (their counts 0), → DONE.
- DONE (one clock): copy counters to res_*; res_valid=1; if res_valid was already 1 and not accepted that cycle, overrun=1. → IDLE.
- res_valid clears on clk with res_valid & res_ready. Result regs stable while res_valid=1 until overwritten by DONE.
- overrun clears only on rst.
- start outside IDLE ignored. A new conversion may start while res_valid=1.

## Timing
- All outputs registered. Reset values: every switch 0, busy 0, res_valid 0, res_* 0, res_err 0, overrun 0, state IDLE.
- start sampled at edge E → sinput/szero and first PWM switch high from E+1; busy high from E+1.
- Run-up lasts exactly npl*PWM_PERIOD clocks.
- cmp at terminating edge: that edge deasserts the phase switch; next switch asserts DEAD_CYC+1 edges later.
- Never two switches high in the same cycle, except sinput/szero together with one of sp_main/sn_main in run-up.
- rst mid-conversion: next cycle all outputs at reset values; partial result discarded.
- DONE coinciding with res_ready on an old result: old accepted, new loaded, res_valid stays 1, no overrun.

## Test plan
- NSTAGE=3, DEAD_CYC=1, npl=2, cmp=1 throughout run-up → cnt_n=2, cnt_p=0, sn_main high 400 clocks, run-up 500 clocks.
- cmp drops 37 clocks into RUNDOWN; stages end after 5, 9, 3 clocks → res_rd=37, res_stg={3,9,5}, res_err=0, one all-off clock between phases.
- cmp stuck 1 in RUNDOWN, RD_W=12 → res_rd=4095, res_err=1, stages 0, DONE reached.
- res_ready held 0, two conversions → second result visible, overrun=1; res_ready=1 → res_valid falls next clock.
- meas_zero=1, npl=0 → szero high 250 clocks, sinput never high, cnt_n+cnt_p=1.
- rst asserted in STAGE(1) → next clock all switches 0, busy 0; start in RUNUP ignored (counts unchanged).
